cs_microsequencer: RTL and testbench

- Next-address controller for the 11-bit control-store address register.
- Each cycle, chooses among four next addresses:
  - increment (current address +1),
  - conditional or unconditional jump to JADDR,
  - opcode decode,
  - trap vector.
- Holds the address while a memory access waits for ACK.
- Sits between the microinstruction register fields (COND, JADDR, MEM_REQ), the IR/PSR flags, and the control-store ROM address input.

---
 rtl/cs_seq_if.sv | 48 ++++
 rtl/cs_microsequencer.sv | 166 ++++++++++++++++
 tb/tb_cs_microsequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cs_seq_if.sv
// Bundle between the microinstruction/IR/PSR fields and the control-store next-address sequencer.
// The CALL/RET/STK_ERR signals exist only when SEQ_CALL_STACK_EN is defined.
interface cs_seq_if #(
    parameter int ADDR_W = 11
);
    logic [2:0]        COND;
    logic [ADDR_W-1:0] JADDR;
    logic              MEM_REQ;
    logic              ACK;
    logic [1:0]        IR_OP;
    logic [5:0]        IR_OP3;
    logic              IR_B13;
    logic              PSR_N;
    logic              PSR_Z;
    logic              PSR_V;
    logic              PSR_C;
    logic              IRQ;
    logic              IEN_SET;
    logic [ADDR_W-1:0] CS_ADDR;
    logic              STALL;
    logic              IRQ_ACK;
    logic [1:0]        SEQ_STATE;
`ifdef SEQ_CALL_STACK_EN
    logic              CALL;
    logic              RET;
    logic              STK_ERR;
`endif

    modport master (
`ifdef SEQ_CALL_STACK_EN
        output CALL, RET,
        input  STK_ERR,
`endif
        output COND, JADDR, MEM_REQ, ACK, IR_OP, IR_OP3, IR_B13,
        output PSR_N, PSR_Z, PSR_V, PSR_C, IRQ, IEN_SET,
        input  CS_ADDR, STALL, IRQ_ACK, SEQ_STATE
    );

    modport slave (
`ifdef SEQ_CALL_STACK_EN
        input  CALL, RET,
        output STK_ERR,
`endif
        input  COND, JADDR, MEM_REQ, ACK, IR_OP, IR_OP3, IR_B13,
        input  PSR_N, PSR_Z, PSR_V, PSR_C, IRQ, IEN_SET,
        output CS_ADDR, STALL, IRQ_ACK, SEQ_STATE
    );
endinterface

// File: rtl/cs_microsequencer.sv
// Control-store next-address sequencer: increment / branch / decode / trap, holding during memory waits.
// Define SEQ_CALL_STACK_EN to add a 4-entry micro-subroutine return stack (CALL/RET/STK_ERR).
module cs_microsequencer #(
    parameter int                ADDR_W   = 11,
    parameter logic [ADDR_W-1:0] TRAP_VEC = 11'd2040,
    parameter logic              DEC_MSB  = 1'b1
) (
    input  logic    CLK,
    input  logic    RESET,
    cs_seq_if.slave bus
);
    typedef enum logic [1:0] {
        S_RUN  = 2'b00,
        S_WAIT = 2'b01,
        S_TRAP = 2'b10
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next, addr_inc, dec_addr, na;
    logic              ien_reg, ien_next, irq_ack_reg;
    logic [7:0]        cond_hit;
    logic              jump_taken, is_decode, stall, advance, trap_entry, load_na;
    logic              ret_req;

    assign addr_inc = addr_reg + ADDR_W'(1);
    assign dec_addr = ADDR_W'({DEC_MSB, bus.IR_OP, bus.IR_OP3, 2'b00});

    // Indexed by COND: 000 never jumps, 110 always jumps, 111 is decode (handled separately).
    assign cond_hit   = {1'b0, 1'b1, bus.IR_B13, bus.PSR_C, bus.PSR_V, bus.PSR_Z, bus.PSR_N, 1'b0};
    assign is_decode  = (bus.COND == 3'b111) && !ret_req;
    assign jump_taken = cond_hit[bus.COND] && !ret_req;

`ifdef SEQ_CALL_STACK_EN
    localparam int DEPTH = 4;

    logic [DEPTH-1:0][ADDR_W-1:0] stk_reg, stk_next;
    logic [2:0]                   depth_reg, depth_next;
    logic                         stk_err_reg, push, pop;

    assign ret_req = bus.RET;
    assign push    = load_na && bus.CALL && jump_taken;
    assign pop     = load_na && ret_req;

    // Entry 0 is the top; a push into a full stack shifts the oldest entry out of the bottom.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stk
            logic [ADDR_W-1:0] from_above, from_below;
            if (gi == 0) begin : g_top
                assign from_above = addr_inc;
            end else begin : g_mid
                assign from_above = stk_reg[gi-1];
            end
            if (gi == DEPTH - 1) begin : g_bot
                assign from_below = '0;
            end else begin : g_up
                assign from_below = stk_reg[gi+1];
            end
            assign stk_next[gi] = push ? from_above : (pop ? from_below : stk_reg[gi]);
        end
    endgenerate

    always_comb begin
        depth_next = depth_reg;
        if (push && depth_reg != 3'(DEPTH)) begin
            depth_next = depth_reg + 3'd1;
        end else if (pop && depth_reg != 3'd0) begin
            depth_next = depth_reg - 3'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stk_reg     <= '0;
            depth_reg   <= 3'd0;
            stk_err_reg <= 1'b0;
        end else begin
            stk_reg   <= stk_next;
            depth_reg <= depth_next;
            if (pop && depth_reg == 3'd0) begin
                stk_err_reg <= 1'b1;
            end
        end
    end

    assign bus.STK_ERR = stk_err_reg;
`else
    assign ret_req = 1'b0;
`endif

    always_comb begin
        na = addr_inc;
        if (is_decode) begin
            na = dec_addr;
        end else if (jump_taken) begin
            na = bus.JADDR;
        end
`ifdef SEQ_CALL_STACK_EN
        if (ret_req) begin
            na = (depth_reg == 3'd0) ? '0 : stk_reg[0];
        end
`endif
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        ien_next   = ien_reg;
        stall      = 1'b0;
        advance    = 1'b0;
        trap_entry = 1'b0;
        load_na    = 1'b0;
        case (state_reg)
            S_RUN: begin
                if (bus.MEM_REQ && !bus.ACK) begin
                    state_next = S_WAIT;
                    stall      = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
            S_WAIT: begin
                stall   = 1'b1;
                advance = bus.ACK;
            end
            S_TRAP: load_na = 1'b1;
            default: state_next = S_RUN;
        endcase
        // Interrupts are only taken when a decode actually advances.
        if (advance && is_decode && bus.IRQ && ien_reg) begin
            trap_entry = 1'b1;
        end else if (advance) begin
            load_na = 1'b1;
        end
        if (trap_entry) begin
            state_next = S_TRAP;
            addr_next  = TRAP_VEC;
        end else if (load_na) begin
            state_next = S_RUN;
            addr_next  = na;
        end
        if (trap_entry) begin
            ien_next = 1'b0;
        end else if (bus.IEN_SET) begin
            ien_next = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg   <= S_RUN;
            addr_reg    <= '0;
            ien_reg     <= 1'b1;
            irq_ack_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            ien_reg     <= ien_next;
            irq_ack_reg <= trap_entry;
        end
    end

    assign bus.CS_ADDR   = addr_reg;
    assign bus.STALL     = stall && !RESET;
    assign bus.IRQ_ACK   = irq_ack_reg;
    assign bus.SEQ_STATE = state_reg;
endmodule

// File: tb/tb_cs_microsequencer.sv
// Self-checking bench for cs_microsequencer: vector table, directed wait/trap/reset sequences, random vs model.
module tb_cs_microsequencer;
    localparam int AW   = 11;
    localparam int TRAP = 2040;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    cs_seq_if #(.ADDR_W(AW)) bus ();

    cs_microsequencer #(.ADDR_W(AW)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [10:0] start;
        logic [2:0]  cond;
        logic [10:0] jaddr;
        logic [4:0]  flags;   // {B13, C, V, Z, N}
        logic [1:0]  op;
        logic [5:0]  op3;
        logic [10:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[16];

    // Reference model state; state codes follow SEQ_STATE (0 RUN, 1 WAIT, 2 TRAP).
    int m_addr, m_state, m_ien, m_irqack;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.COND = 3'd0; bus.JADDR = '0; bus.MEM_REQ = 1'b0; bus.ACK = 1'b0;
        bus.IR_OP = 2'd0; bus.IR_OP3 = 6'd0; bus.IR_B13 = 1'b0;
        bus.PSR_N = 1'b0; bus.PSR_Z = 1'b0; bus.PSR_V = 1'b0; bus.PSR_C = 1'b0;
        bus.IRQ = 1'b0; bus.IEN_SET = 1'b0;
`ifdef SEQ_CALL_STACK_EN
        bus.CALL = 1'b0; bus.RET = 1'b0;
`endif
    endtask

    task automatic set_flags(logic [4:0] f);
        {bus.IR_B13, bus.PSR_C, bus.PSR_V, bus.PSR_Z, bus.PSR_N} = f;
    endtask

    // Next address straight from the branch rules, using plain arithmetic.
    function automatic int model_na(int addr);
        int hit[8];
        hit = '{0, int'(bus.PSR_N), int'(bus.PSR_Z), int'(bus.PSR_V), int'(bus.PSR_C),
                int'(bus.IR_B13), 1, 0};
        if (bus.COND == 3'd7) return 1024 + int'(bus.IR_OP) * 256 + int'(bus.IR_OP3) * 4;
        if (hit[bus.COND] != 0) return int'(bus.JADDR);
        return (addr + 1) % 2048;
    endfunction

    task automatic model_step();
        bit go, trap;
        if (m_state == 2)      go = 1'b1;
        else if (m_state == 1) go = bus.ACK;
        else                   go = !(bus.MEM_REQ && !bus.ACK);
        trap = (m_state != 2) && go && bus.COND == 3'd7 && bus.IRQ && (m_ien != 0);
        if (!go) begin
            m_state = 1;
        end else if (trap) begin
            m_addr  = TRAP;
            m_state = 2;
        end else begin
            m_addr  = model_na(m_addr);
            m_state = 0;
        end
        if (trap) m_ien = 0;
        else if (bus.IEN_SET) m_ien = 1;
        m_irqack = int'(trap);
    endtask

    initial begin
        vecs[0]  = '{11'd2047, 3'b000, 11'h000, 5'b00000, 2'b00, 6'o00, 11'd0,    "wrap_inc"};
        vecs[1]  = '{11'd100,  3'b010, 11'h155, 5'b00010, 2'b00, 6'o00, 11'h155,  "z_taken"};
        vecs[2]  = '{11'd100,  3'b010, 11'h155, 5'b00000, 2'b00, 6'o00, 11'd101,  "z_not"};
        vecs[3]  = '{11'h010,  3'b001, 11'h222, 5'b00001, 2'b00, 6'o00, 11'h222,  "n_taken"};
        vecs[4]  = '{11'h010,  3'b001, 11'h222, 5'b11110, 2'b00, 6'o00, 11'h011,  "n_not"};
        vecs[5]  = '{11'h030,  3'b011, 11'h7FF, 5'b00100, 2'b00, 6'o00, 11'h7FF,  "v_taken"};
        vecs[6]  = '{11'h030,  3'b100, 11'h003, 5'b10111, 2'b00, 6'o00, 11'h031,  "c_not"};
        vecs[7]  = '{11'h030,  3'b100, 11'h003, 5'b01000, 2'b00, 6'o00, 11'h003,  "c_taken"};
        vecs[8]  = '{11'h040,  3'b101, 11'h123, 5'b10000, 2'b00, 6'o00, 11'h123,  "b13_taken"};
        vecs[9]  = '{11'h7FF,  3'b101, 11'h123, 5'b01111, 2'b00, 6'o00, 11'h000,  "b13_not_wrap"};
        vecs[10] = '{11'h050,  3'b110, 11'h0AA, 5'b00000, 2'b00, 6'o00, 11'h0AA,  "jump_uncond"};
        vecs[11] = '{11'h005,  3'b111, 11'h111, 5'b11111, 2'b10, 6'o00, 11'h600,  "dec_op2"};
        vecs[12] = '{11'h005,  3'b111, 11'h111, 5'b00000, 2'b10, 6'o70, 11'h6E0,  "dec_op2_38"};
        vecs[13] = '{11'h005,  3'b111, 11'h111, 5'b00000, 2'b00, 6'o00, 11'h400,  "dec_op0"};
        vecs[14] = '{11'h005,  3'b111, 11'h111, 5'b00000, 2'b00, 6'o70, 11'h4E0,  "dec_op0_38"};
        vecs[15] = '{11'h005,  3'b111, 11'h111, 5'b00000, 2'b11, 6'o77, 11'h7FC,  "dec_max"};

        // Reset state, then free-running increment.
        idle();
        #12;
        chk("rst_addr", bus.CS_ADDR, 0);
        chk("rst_state", bus.SEQ_STATE, 0);
        chk("rst_irq_ack", bus.IRQ_ACK, 0);
        chk("rst_stall", bus.STALL, 0);
        RESET = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("inc_addr", bus.CS_ADDR, i);
            $display("inc cycle %0d addr=%0d", i, bus.CS_ADDR);
        end

        // Table of single-step next-address cases, each preset by an unconditional jump.
        for (int i = 0; i < 16; i++) begin
            idle();
            bus.COND = 3'b110; bus.JADDR = vecs[i].start;
            tick();
            chk("preset", bus.CS_ADDR, vecs[i].start);
            bus.COND = vecs[i].cond; bus.JADDR = vecs[i].jaddr;
            set_flags(vecs[i].flags);
            bus.IR_OP = vecs[i].op; bus.IR_OP3 = vecs[i].op3;
            tick();
            chk(vecs[i].name, bus.CS_ADDR, vecs[i].exp);
            $display("vec %0d %s start=%0h next=%0h", i, vecs[i].name, vecs[i].start, bus.CS_ADDR);
        end

        // Memory wait: three stalled cycles then ACK releases the jump.
        idle();
        bus.COND = 3'b110; bus.JADDR = 11'h020; bus.MEM_REQ = 1'b1;
        #1;
        chk("wait_stall_run", bus.STALL, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_hold", bus.CS_ADDR, 11'h7FC);
            chk("wait_state", bus.SEQ_STATE, 1);
            chk("wait_stall", bus.STALL, 1);
            $display("wait cycle %0d addr=%0h stall=%0b", i, bus.CS_ADDR, bus.STALL);
        end
        bus.ACK = 1'b1;
        tick();
        bus.MEM_REQ = 1'b0; bus.ACK = 1'b0;
        chk("ack_addr", bus.CS_ADDR, 11'h020);
        chk("ack_state", bus.SEQ_STATE, 0);
        #1;
        chk("ack_stall", bus.STALL, 0);
        $display("ack addr=%0h", bus.CS_ADDR);

        // ACK without a request is ignored.
        bus.COND = 3'b000; bus.ACK = 1'b1;
        tick();
        chk("stray_ack", bus.CS_ADDR, 11'h021);
        chk("stray_ack_state", bus.SEQ_STATE, 0);

        // Interrupt trap, IEN masking and re-enable.
        idle();
        bus.COND = 3'b111; bus.IRQ = 1'b1;
        tick();
        chk("trap_addr", bus.CS_ADDR, TRAP);
        chk("trap_ack", bus.IRQ_ACK, 1);
        chk("trap_state", bus.SEQ_STATE, 2);
        bus.COND = 3'b000;
        tick();
        chk("post_trap_addr", bus.CS_ADDR, TRAP + 1);
        chk("post_trap_ack", bus.IRQ_ACK, 0);
        chk("post_trap_state", bus.SEQ_STATE, 0);
        bus.COND = 3'b111;
        tick();
        chk("masked_addr", bus.CS_ADDR, 11'h400);
        chk("masked_ack", bus.IRQ_ACK, 0);
        bus.COND = 3'b000; bus.IEN_SET = 1'b1;
        tick();
        bus.IEN_SET = 1'b0; bus.COND = 3'b111;
        tick();
        chk("reen_trap_addr", bus.CS_ADDR, TRAP);
        chk("reen_trap_ack", bus.IRQ_ACK, 1);
        bus.COND = 3'b000; bus.IEN_SET = 1'b1;
        tick();
        bus.COND = 3'b111;
        tick();
        chk("set_vs_trap_addr", bus.CS_ADDR, TRAP);
        bus.IEN_SET = 1'b0; bus.COND = 3'b000;
        tick();
        bus.COND = 3'b111;
        tick();
        chk("trap_wins_ien", bus.CS_ADDR, 11'h400);
        chk("trap_wins_state", bus.SEQ_STATE, 0);
        $display("trap sequence done addr=%0h", bus.CS_ADDR);

        // Asynchronous reset in the middle of a wait.
        idle();
        bus.COND = 3'b110; bus.JADDR = 11'h033; bus.MEM_REQ = 1'b1;
        tick();
        chk("pre_rst_state", bus.SEQ_STATE, 1);
        #3;
        RESET = 1'b1;
        #1;
        chk("async_rst_addr", bus.CS_ADDR, 0);
        chk("async_rst_state", bus.SEQ_STATE, 0);
        chk("async_rst_stall", bus.STALL, 0);
        $display("async reset addr=%0h state=%0d", bus.CS_ADDR, bus.SEQ_STATE);
        idle();
        @(posedge CLK);
        #3;
        RESET = 1'b0;
        m_addr = 0; m_state = 0; m_ien = 1; m_irqack = 0;

        // Random stimulus against the reference model.
        for (int i = 0; i < 400; i++) begin
            bus.COND    = 3'($urandom_range(0, 7));
            bus.JADDR   = 11'($urandom_range(0, 2047));
            bus.MEM_REQ = ($urandom_range(0, 3) == 0);
            bus.ACK     = ($urandom_range(0, 2) == 0);
            bus.IRQ     = 1'($urandom_range(0, 1));
            bus.IEN_SET = ($urandom_range(0, 7) == 0);
            bus.IR_OP   = 2'($urandom_range(0, 3));
            bus.IR_OP3  = 6'($urandom_range(0, 63));
            set_flags(5'($urandom_range(0, 31)));
            #1;
            chk("rnd_stall", bus.STALL,
                (m_state == 1) || (m_state == 0 && bus.MEM_REQ && !bus.ACK));
            model_step();
            tick();
            chk("rnd_addr", bus.CS_ADDR, m_addr);
            chk("rnd_state", bus.SEQ_STATE, m_state);
            chk("rnd_irq_ack", bus.IRQ_ACK, m_irqack);
            $display("rnd %0d cond=%0d addr=%0h state=%0d", i, bus.COND, bus.CS_ADDR, bus.SEQ_STATE);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
